tl_a_arb: RTL
=============

Name: tl_a_arb

Overview:
- N-to-1 TileLink arbiter sitting directly upstream of the TL channel buffer.
- Merges the A channels of NUM_MST masters into one downstream port. Arbitration is round-robin, with a lock that holds for multi-beat Put messages.
- Routes D responses back to the issuing master by source-ID partition.
- B/C/E coherence channels pass straight through to master 0, the only caching client.

Parameters:
- NUM_MST, 2, number of upstream masters (2..8).
- IDX_W, $clog2(NUM_MST), master-index field width; the top IDX_W bits of the tl_pkg source field.
- BEAT_BYTES, 8, data bytes per beat (log2 = 3).
- MAX_SIZE, 6, largest legal a_bits.size (64 B → 8 beats).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-low reset
- mst  TL_BUS.Master  array [NUM_MST]  upstream-facing ports, one per master
- slv  TL_BUS.Slave  interface  downstream-facing port; feeds the TL buffer
- err_o  output  1  sticky source-partition violation flag

Behaviour:
- Reset (rst_i low, async):
  - rr_ptr=0, lock=0, hold=0, beat_cnt=0, err_o=0.
  - slv.a_valid=0; all mst[i].a_ready=0.
  - slv.d_ready is the combinational routed d_ready described under D routing.
- A arbitration:
  - Combinational, zero added latency.
  - When not hold/lock: winner = first valid master searching rr_ptr, rr_ptr+1, … modulo NUM_MST.
  - slv.a_valid = mst[winner].a_valid; slv.a_bits = mst[winner].a_bits.
  - mst[winner].a_ready = slv.a_ready; all other a_ready = 0.
- hold:
  - Set when slv.a_valid=1 and slv.a_ready=0; the registered grant idx is frozen.
  - Required so a presented beat is never withdrawn or swapped.
  - Cleared on the fire of that beat.
- Beat count:
  - beats = 1 for Get, Acquire*, ArithmeticData/LogicalData with size≤3.
  - For PutFullData/PutPartialData/Arithmetic/Logical with size>3: beats = 2^(size-3).
  - size>MAX_SIZE is treated as MAX_SIZE and sets err_o.
- lock:
  - On first-beat fire with beats>1: lock=1, beat_cnt=beats-1, grant held.
  - Each further fire decrements beat_cnt; lock clears on the fire with beat_cnt==1.
- rr_ptr:
  - Updated only on the last beat of a message: rr_ptr = (grant+1) mod NUM_MST.
  - No update on idle cycles.
- A source check: if mst[i] fires with source[top IDX_W] != i, the beat is forwarded unchanged and err_o is set. err_o stays set until reset.
- D routing:
  - idx = slv.d_bits.source[top IDX_W].
  - mst[idx].d_valid = slv.d_valid; all mst[*].d_bits = slv.d_bits.
  - slv.d_ready = mst[idx].d_ready.
  - If idx ≥ NUM_MST: slv.d_ready=1 (beat dropped), err_o=1.
  - Multi-beat D needs no lock; every beat carries its source.
  - A and D are independent; fires on both in the same cycle are legal.
- B/C/E:
  - Wired straight through between slv and mst[0].
  - For i>0: b_valid=0, c_ready=0, e_ready=0.
  - mst[i>0] c/e valids are ignored.
- Reset mid-message: lock, beat_cnt and hold clear immediately; the downstream buffer is reset by the same rst_i.

Test Plan:
- Both masters issue a continuous Get stream, slv.a_ready=1 → grants alternate m0,m1,m0,m1; rr_ptr toggles each cycle; 100 beats split 50/50.
- m1 PutFullData size=6 (8 beats) while m0 holds a_valid=1 → m0 is stalled for exactly 8 fires; m0's Get fires on the cycle after m1's 8th beat.
- slv.a_ready=0 for 3 cycles with m0 granted, m1 raising valid in cycle 2 → slv.a_bits stays m0's beat unchanged until it fires; m1 is granted next.
- D AccessAckData size=5 (4 beats), source top bit=1, mst[1].d_ready toggling → all 4 beats reach m1 only, mst[0].d_valid=0 throughout, slv.d_ready mirrors mst[1].d_ready.
- m0 fires A with source top bit=1 → beat forwarded unchanged, err_o=1 from the next cycle and sticky until rst_i low.
- rst_i asserted on beat 3 of an 8-beat Put → slv.a_valid=0 asynchronously; after release, lock=0, rr_ptr=0, and m0 is granted first.

Source files
------------

// File: rtl/tl_a_arb_if.sv
// TileLink bus bundle (A/B/C/D/E channels) shared by the arbiter and its neighbours.
// Modports are named after the device on the far side: the arbiter takes a Master view per upstream port.
interface TL_BUS #(
  parameter int SRC_W  = 8,
  parameter int SINK_W = 2
);
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [2:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [31:0]       a_address;
  logic [7:0]        a_mask;
  logic [63:0]       a_data;

  logic              b_valid;
  logic              b_ready;
  logic [2:0]        b_opcode;
  logic [1:0]        b_param;
  logic [2:0]        b_size;
  logic [SRC_W-1:0]  b_source;
  logic [31:0]       b_address;

  logic              c_valid;
  logic              c_ready;
  logic [2:0]        c_opcode;
  logic [2:0]        c_param;
  logic [2:0]        c_size;
  logic [SRC_W-1:0]  c_source;
  logic [31:0]       c_address;
  logic [63:0]       c_data;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic [SINK_W-1:0] d_sink;
  logic [63:0]       d_data;
  logic              d_error;

  logic              e_valid;
  logic              e_ready;
  logic [SINK_W-1:0] e_sink;

  modport Master (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output b_valid, b_opcode, b_param, b_size, b_source, b_address,
    input  b_ready,
    input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data,
    output c_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    input  d_ready,
    input  e_valid, e_sink,
    output e_ready
  );

  modport Slave (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  b_valid, b_opcode, b_param, b_size, b_source, b_address,
    output b_ready,
    output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data,
    input  c_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    output d_ready,
    output e_valid, e_sink,
    input  e_ready
  );
endinterface

// File: rtl/tl_a_arb.sv
// N-to-1 TileLink A-channel arbiter: round-robin with a burst lock for multi-beat puts,
// source-partitioned D routing, and coherence channels tied to master 0.
module tl_a_arb #(
  parameter int NUM_MST    = 2,
  parameter int IDX_W      = $clog2(NUM_MST),
  parameter int BEAT_BYTES = 8,
  parameter int MAX_SIZE   = 6,
  parameter int SRC_W      = 8
) (
  input  logic   clk_i,
  input  logic   rst_i,
  TL_BUS.Master  mst [NUM_MST],
  TL_BUS.Slave   slv,
  output logic   err_o
);

  localparam int LOG_BEAT = $clog2(BEAT_BYTES);
  localparam int CNT_W    = MAX_SIZE - LOG_BEAT + 1;
  localparam int A_W      = 9 + SRC_W + 32 + 8 + 64;

  logic [NUM_MST-1:0] a_valid_v;
  logic [NUM_MST-1:0] d_ready_v;
  logic [A_W-1:0]     a_pack [NUM_MST];
  logic [A_W-1:0]     a_sel;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   grant;
  logic               hold;
  logic               lock;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   beats;

  logic               a_fire;
  logic               last_beat;
  logic               src_bad;
  logic               size_bad;
  logic               found;
  int                 cand;
  int                 size_eff;

  logic [IDX_W-1:0]   d_idx;
  logic               d_in_range;

  for (genvar i = 0; i < NUM_MST; i++) begin : g_port
    assign a_valid_v[i] = mst[i].a_valid;
    assign a_pack[i]    = {mst[i].a_opcode, mst[i].a_param, mst[i].a_size, mst[i].a_source,
                           mst[i].a_address, mst[i].a_mask, mst[i].a_data};
    assign mst[i].a_ready = rst_i && (grant == IDX_W'(i)) && slv.a_ready;

    assign mst[i].d_valid  = slv.d_valid && d_in_range && (d_idx == IDX_W'(i));
    assign mst[i].d_opcode = slv.d_opcode;
    assign mst[i].d_param  = slv.d_param;
    assign mst[i].d_size   = slv.d_size;
    assign mst[i].d_source = slv.d_source;
    assign mst[i].d_sink   = slv.d_sink;
    assign mst[i].d_data   = slv.d_data;
    assign mst[i].d_error  = slv.d_error;
    assign d_ready_v[i]    = mst[i].d_ready;

    assign mst[i].b_opcode  = slv.b_opcode;
    assign mst[i].b_param   = slv.b_param;
    assign mst[i].b_size    = slv.b_size;
    assign mst[i].b_source  = slv.b_source;
    assign mst[i].b_address = slv.b_address;

    // Only master 0 caches, so it alone sees probes and may release/grant-ack.
    if (i == 0) begin : g_coh
      assign mst[i].b_valid  = slv.b_valid;
      assign slv.b_ready     = mst[i].b_ready;
      assign slv.c_valid     = mst[i].c_valid;
      assign slv.c_opcode    = mst[i].c_opcode;
      assign slv.c_param     = mst[i].c_param;
      assign slv.c_size      = mst[i].c_size;
      assign slv.c_source    = mst[i].c_source;
      assign slv.c_address   = mst[i].c_address;
      assign slv.c_data      = mst[i].c_data;
      assign mst[i].c_ready  = slv.c_ready;
      assign slv.e_valid     = mst[i].e_valid;
      assign slv.e_sink      = mst[i].e_sink;
      assign mst[i].e_ready  = slv.e_ready;
    end else begin : g_nocoh
      logic unused_coh;
      assign mst[i].b_valid = 1'b0;
      assign mst[i].c_ready = 1'b0;
      assign mst[i].e_ready = 1'b0;
      assign unused_coh = ^{mst[i].b_ready, mst[i].c_valid, mst[i].c_opcode, mst[i].c_param,
                            mst[i].c_size, mst[i].c_source, mst[i].c_address, mst[i].c_data,
                            mst[i].e_valid, mst[i].e_sink};
    end
  end

  // While a beat is stalled or a burst is in flight the registered grant is reused,
  // so the downstream buffer never sees a presented beat withdrawn or swapped.
  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    cand  = 0;
    if (hold || lock) begin
      grant = grant_q;
    end else begin
      for (int k = 0; k < NUM_MST; k++) begin
        cand = (int'(rr_ptr) + k) % NUM_MST;
        if (!found && a_valid_v[cand]) begin
          grant = IDX_W'(cand);
          found = 1'b1;
        end
      end
    end
  end

  assign a_sel       = a_pack[grant];
  assign slv.a_valid = rst_i && a_valid_v[grant];
  assign {slv.a_opcode, slv.a_param, slv.a_size, slv.a_source,
          slv.a_address, slv.a_mask, slv.a_data} = a_sel;

  assign a_fire = slv.a_valid && slv.a_ready;

  // Data-carrying opcodes (Put/Arithmetic/Logical, codes 0..3) span 2^(size-3) beats.
  always_comb begin
    size_eff = int'(slv.a_size);
    if (size_eff > MAX_SIZE) size_eff = MAX_SIZE;
    beats = CNT_W'(1);
    if ((slv.a_opcode < 3'd4) && (size_eff > LOG_BEAT)) begin
      beats = CNT_W'(1) << (size_eff - LOG_BEAT);
    end
  end

  assign last_beat = lock ? (beat_cnt == CNT_W'(1)) : (beats == CNT_W'(1));
  assign src_bad   = slv.a_source[SRC_W-1 -: IDX_W] != grant;
  assign size_bad  = int'(slv.a_size) > MAX_SIZE;

  assign d_idx       = slv.d_source[SRC_W-1 -: IDX_W];
  assign d_in_range  = int'(d_idx) < NUM_MST;
  assign slv.d_ready = d_in_range ? d_ready_v[d_idx] : 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_ptr   <= '0;
      grant_q  <= '0;
      hold     <= 1'b0;
      lock     <= 1'b0;
      beat_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      grant_q <= grant;
      hold    <= slv.a_valid && !slv.a_ready;
      if (a_fire) begin
        if (lock) begin
          beat_cnt <= beat_cnt - CNT_W'(1);
          if (beat_cnt == CNT_W'(1)) lock <= 1'b0;
        end else if (beats > CNT_W'(1)) begin
          lock     <= 1'b1;
          beat_cnt <= beats - CNT_W'(1);
        end
        if (last_beat) rr_ptr <= IDX_W'((int'(grant) + 1) % NUM_MST);
      end
      if ((a_fire && (src_bad || size_bad)) || (slv.d_valid && !d_in_range)) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule
